// File: rtl/reg_dump_pkg.sv
// Shared types and constants for the register-file dump reader.
package reg_dump_pkg;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 32 / BYTE_W;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    CSUM,
    DONE
  } state_t;

  function automatic int bytes_per_word(input int data_width);
    return data_width / BYTE_W;
  endfunction

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Byte stream from the dump reader to the UART transmitter (valid/ready, data held while stalled).
interface regfile_dump_reader_if;
  import reg_dump_pkg::*;

  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/reg_dump_word_ser.sv
// Serializes one word MSB byte first; valid rises the cycle after load.
// Byte and valid hold until ready; valid drops on the last byte's handshake.
module reg_dump_word_ser
  import reg_dump_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [BYTE_W-1:0]     data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  hs,
  output logic                  last
);

  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         cnt;

  assign data = shreg[DATA_WIDTH-1 -: BYTE_W];
  assign hs   = valid & ready;
  assign last = (cnt == CW'(BPW - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      shreg <= word;
      cnt   <= '0;
      valid <= 1'b1;
    end else if (hs) begin
      shreg <= shreg << BYTE_W;
      cnt   <= cnt + 1'b1;
      if (last) valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks registers 0..NUM_REGS-1 through the debug read port and streams each word MSB first, 5 cycles/register at full rate.
// tx_data/tx_valid hold under backpressure; REG_DUMP_CHECKSUM_EN appends an XOR-of-all-bytes trailer.
module regfile_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] dbg_ra,
  input  logic [DATA_WIDTH-1:0] dbg_rd,
  regfile_dump_reader_if.master tx
);

  state_t            state, state_nxt;
  logic              ser_load, ser_valid, ser_hs, ser_last;
  logic [BYTE_W-1:0] ser_data;
  logic              last_reg;

  assign last_reg = (dbg_ra == ADDR_WIDTH'(NUM_REGS - 1));

  reg_dump_word_ser #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk   (clk),
    .rst   (rst),
    .load  (ser_load),
    .word  (dbg_rd),
    .data  (ser_data),
    .valid (ser_valid),
    .ready (tx.tx_ready),
    .hs    (ser_hs),
    .last  (ser_last)
  );

`ifdef REG_DUMP_CHECKSUM_EN
  localparam state_t FINAL = CSUM;

  logic [BYTE_W-1:0] csum;
  logic              csum_valid, csum_hs;

  assign csum_hs = csum_valid & tx.tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum       <= '0;
      csum_valid <= 1'b0;
    end else begin
      if (state == IDLE && state_nxt == LOAD) csum <= '0;
      else if (ser_hs)                        csum <= csum ^ ser_data;
      // Trailer goes valid on the same edge the final data byte is folded in.
      if (state == SEND && state_nxt == CSUM) csum_valid <= 1'b1;
      else if (csum_hs)                       csum_valid <= 1'b0;
    end
  end

  assign tx.tx_valid = ser_valid | csum_valid;
  assign tx.tx_data  = csum_valid ? csum : ser_data;
`else
  localparam state_t FINAL = DONE;

  assign tx.tx_valid = ser_valid;
  assign tx.tx_data  = ser_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // done is still high in the first IDLE cycle; a start there counts as coincident and is dropped.
  always_comb begin
    state_nxt = state;
    ser_load  = 1'b0;
    case (state)
      IDLE: if (start && !done) state_nxt = LOAD;
      LOAD: begin
        ser_load  = 1'b1;
        state_nxt = SEND;
      end
      SEND: if (ser_hs && ser_last) state_nxt = last_reg ? FINAL : LOAD;
`ifdef REG_DUMP_CHECKSUM_EN
      CSUM: if (csum_hs) state_nxt = DONE;
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      dbg_ra <= '0;
    end else begin
      done <= (state == DONE);
      if (state == IDLE && state_nxt == LOAD) begin
        busy   <= 1'b1;
        dbg_ra <= '0;
      end
      if (state == SEND && state_nxt == LOAD) dbg_ra <= dbg_ra + 1'b1;
      if (state == DONE) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: byte-position table, snapshot-model stream compare, corner sequences.
module tb_regfile_dump_reader;
  import reg_dump_pkg::*;

  typedef logic [31:0] regs_t [32];
  typedef struct {
    int         pos;
    logic [7:0] exp;
  } vec_t;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int NB = 32 * BYTES_PER_WORD + CS;

  logic        clk = 1'b0;
  logic        rst, start, busy, done;
  logic [4:0]  dbg_ra;
  logic [31:0] dbg_rd;
  regs_t       rf;

  regfile_dump_reader_if tx_if ();

  regfile_dump_reader #(.NUM_REGS(32), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .dbg_ra (dbg_ra),
    .dbg_rd (dbg_rd),
    .tx     (tx_if)
  );

  always #5 clk = ~clk;

  // Register file never writes R0.
  assign dbg_rd = (dbg_ra == 5'd0) ? 32'd0 : rf[dbg_ra];

  int         pass_cnt = 0, total_cnt = 0;
  int         cyc = 0, s_cyc = 0, done_cyc = 0, done_cnt = 0, hold_err = 0;
  int         ready_pct = 100;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_dat = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  function automatic logic [7:0] getb(input int i);
    return (i < got.size()) ? got[i] : 8'hxx;
  endfunction

  // Reference: each register's value at its own LOAD, big-endian bytes, optional XOR trailer.
  task automatic build_exp(input regs_t snap);
    logic [7:0] b;
    logic [7:0] cs;
    cs = 8'h00;
    exp_q.delete();
    for (int r = 0; r < 32; r++)
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        b = (r == 0) ? 8'h00 : snap[r][31 - 8*k -: 8];
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    if (CS != 0) exp_q.push_back(cs);
  endtask

  task automatic compare_stream(input string name);
    int m;
    m = 0;
    chk({name, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (getb(i) !== exp_q[i]) m++;
    chk({name, "_bytes_wrong"}, m, 0);
    chk({name, "_hold"}, hold_err, 0);
  endtask

  task automatic rand_regs();
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
  endtask

  task automatic begin_dump(input int pct);
    ready_pct = pct;
    got.delete();
    done_cnt = 0;
    hold_err = 0;
    @(posedge clk); #1;
    start = 1'b1;
    s_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("valid_in_load", tx_if.tx_valid, 0);
  endtask

  task automatic wait_bytes(input int n);
    int i;
    i = 0;
    while (got.size() < n && i < 3000) begin
      @(negedge clk); #1;
      i++;
    end
    chk("reach_byte", got.size() >= n, 1);
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (done_cnt == 0 && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    chk("done_seen", done_cnt, 1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    tx_if.tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      tx_if.tx_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Handshakes are judged at the negedge preceding the edge that completes them.
  initial forever begin
    @(negedge clk);
    if (rst) prev_stall = 1'b0;
    else begin
      if (prev_stall && (!tx_if.tx_valid || tx_if.tx_data !== prev_dat)) hold_err++;
      if (tx_if.tx_valid && tx_if.tx_ready) got.push_back(tx_if.tx_data);
      prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
      prev_dat   = tx_if.tx_data;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial begin
    vec_t  tbl[12];
    regs_t snap;

    tbl = '{'{0, 8'h00}, '{3, 8'h00}, '{4, 8'hDE}, '{5, 8'hAD}, '{6, 8'hBE}, '{7, 8'hEF},
            '{8, 8'h00}, '{11, 8'h02}, '{124, 8'h01}, '{125, 8'h23}, '{126, 8'h45}, '{127, 8'h67}};

    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = i;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", tx_if.tx_valid, 0);
    chk("rst_data", tx_if.tx_data, 0);
    chk("rst_ra", dbg_ra, 0);
    rst = 1'b0;

    // Full dump, no backpressure
    rf[1] = 32'hDEADBEEF;
    rf[31] = 32'h01234567;
    snap = rf;
    build_exp(snap);
    begin_dump(100);
    wait_done(400);
    chk("done_latency", done_cyc - s_cyc, 162 + CS);
    for (int i = 0; i < 12; i++) chk($sformatf("byte%0d", tbl[i].pos), getb(tbl[i].pos), tbl[i].exp);
    compare_stream("full");
    repeat (3) @(posedge clk);
    #1;
    chk("busy_after_done", busy, 0);
    chk("ra_holds_last", dbg_ra, 31);
    chk("done_once", done_cnt, 1);

    // Random contents under backpressure
    for (int t = 0; t < 3; t++) begin
      rand_regs();
      snap = rf;
      build_exp(snap);
      begin_dump((t == 2) ? 70 : 30);
      wait_done(3000);
      compare_stream($sformatf("bp%0d", t));
    end

    // Start while busy and on the done cycle
    rand_regs();
    snap = rf;
    build_exp(snap);
    begin_dump(100);
    wait_bytes(10);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(400);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("ign_busy", busy, 0);
    chk("ign_valid", tx_if.tx_valid, 0);
    chk("ign_done_cnt", done_cnt, 1);
    compare_stream("ign");

    // Reset mid-dump, then a fresh dump from R0
    begin_dump(100);
    wait_bytes(50);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_valid", tx_if.tx_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ra", dbg_ra, 0);
    chk("abort_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    begin_dump(100);
    wait_done(400);
    compare_stream("restart");

    // Writes while R5 is on the wire: R20 (later) visible, R3 (earlier) not
    for (int i = 0; i < 32; i++) rf[i] = i;
    snap = rf;
    snap[20] = 32'hAAAAAAAA;
    build_exp(snap);
    begin_dump(100);
    wait_bytes(21);
    rf[20] = 32'hAAAAAAAA;
    rf[3]  = 32'h55555555;
    wait_done(400);
    chk("r20_b0", getb(80), 8'hAA);
    chk("r20_b3", getb(83), 8'hAA);
    chk("r3_b3", getb(15), 8'h03);
    compare_stream("wr");

`ifdef REG_DUMP_CHECKSUM_EN
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[1] = 32'hDEADBEEF;
    snap = rf;
    build_exp(snap);
    begin_dump(100);
    wait_done(400);
    chk("csum_byte", getb(128), 8'h22);
    compare_stream("csum");
`endif

    chk("stream_bytes_total", exp_q.size(), NB);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
